// File: rtl/led_fx_driver.sv
// LED output stage: latches the PIO pattern on PWM period boundaries and drives
// the pins with global PWM dimming and optional blinking, configured over Avalon-MM.
module led_fx_driver #(
  parameter int PRESCALE = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  led_pattern,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led_out
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } blink_state_t;

  // Bus handshake: a write is accepted on the rising edge where chipselect is
  // high and write_n is low; reads are combinational with zero wait states.
  logic         w_wr;
  logic         w_unused_ok;

  logic         r_enable;
  logic         r_blink_en;
  logic [7:0]   r_duty;
  logic [15:0]  r_blink_div;

  logic [PW-1:0] r_pre_cnt;
  logic          w_tick;
  logic [7:0]    r_pwm_cnt;
  logic          w_pwm_on;
  logic [7:0]    r_pattern_q;
  logic [7:0]    r_led_out;

  blink_state_t  r_state;
  blink_state_t  w_state_nxt;
  logic [15:0]   r_blink_cnt;
  logic [15:0]   w_blink_cnt_nxt;
  logic          w_restart;
  logic          w_blink_phase;

  assign w_wr        = chipselect && !write_n;
  assign w_unused_ok = &{1'b0, writedata[31:16]};

  // Configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable    <= 1'b0;
      r_blink_en  <= 1'b0;
      r_duty      <= 8'hFF;
      r_blink_div <= 16'd0;
    end else if (w_wr) begin
      case (address)
        2'd0: begin
          r_enable   <= writedata[0];
          r_blink_en <= writedata[1];
        end
        2'd1:    r_duty      <= writedata[7:0];
        2'd2:    r_blink_div <= writedata[15:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[1:0]  = {r_blink_en, r_enable};
      2'd1: readdata[7:0]  = r_duty;
      2'd2: readdata[15:0] = r_blink_div;
      2'd3: begin
        readdata[15:8] = r_pattern_q;
        readdata[0]    = w_blink_phase;
      end
      default: readdata = '0;
    endcase
  end

  // Free-running prescaler, PWM counter and boundary-aligned pattern latch
  assign w_tick = (r_pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt   <= '0;
      r_pwm_cnt   <= 8'd0;
      r_pattern_q <= 8'd0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PW'(1);
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (r_pwm_cnt == 8'hFF) r_pattern_q <= led_pattern;
    end
  end

  assign w_pwm_on = (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);

  // Blink machine: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ON;
      r_blink_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
    end
  end

  // A divider write or a blink_en rising write restarts the half-period in ON,
  // overriding any tick landing on the same edge.
  assign w_restart = w_wr && ((address == 2'd2) ||
                              ((address == 2'd0) && writedata[1] && !r_blink_en));

  // Blink machine: next state
  always_comb begin
    w_state_nxt     = r_state;
    w_blink_cnt_nxt = r_blink_cnt;
    if (w_restart || (r_blink_div == 16'd0)) begin
      w_state_nxt     = ST_ON;
      w_blink_cnt_nxt = 16'd0;
    end else if (w_tick) begin
      if (r_blink_cnt == r_blink_div - 16'd1) begin
        w_state_nxt     = (r_state == ST_ON) ? ST_OFF : ST_ON;
        w_blink_cnt_nxt = 16'd0;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + 16'd1;
      end
    end
  end

  // Blink machine: outputs
  always_comb begin
    w_blink_phase = (r_state == ST_ON);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led_out <= 8'd0;
    end else if (r_enable) begin
      r_led_out <= r_pattern_q & {8{w_pwm_on}} & {8{w_blink_phase | !r_blink_en}};
    end else begin
      r_led_out <= 8'd0;
    end
  end

  assign led_out = r_led_out;

endmodule

// File: tb/tb_led_fx_driver.sv
// Directed bench for led_fx_driver with PRESCALE=4: reset values, full-on,
// PWM duty, glitch-free pattern latch, blink timing, restart and mid-run reset.
module tb_led_fx_driver;

  logic        clk;
  logic        reset;
  logic [7:0]  led_pattern;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference PWM period position: counts edges since reset, wraps at 256
  logic [7:0] pwm_ref;

  led_fx_driver #(.PRESCALE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .led_pattern(led_pattern),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  // Clock and reset-aligned reference counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (reset) pwm_ref <= 8'd0;
    else       pwm_ref <= pwm_ref + 8'd1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic wait_pwm(input logic [7:0] v);
    int n = 0;
    while (pwm_ref !== v && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_pwm", {24'd0, pwm_ref}, {24'd0, v});
  endtask

  task automatic wait_led(input string tag, input logic [7:0] v, input int lim);
    int n = 0;
    while (led_out !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, {24'd0, led_out}, {24'd0, v});
  endtask

  task automatic measure(input logic [7:0] v, output int len);
    len = 0;
    while (led_out === v && len < 100) begin
      @(negedge clk);
      len++;
    end
  endtask

  initial begin
    int bad;
    int on_cnt;
    int len;
    int n;

    reset       = 1'b1;
    led_pattern = 8'hFF;
    address     = 2'd0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = 32'd0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_led", {24'd0, led_out}, 32'd0);
    read_check("rst_ctrl", 2'd0, 32'h0000_0000);
    read_check("rst_duty", 2'd1, 32'h0000_00FF);
    read_check("rst_div", 2'd2, 32'h0000_0000);
    read_check("rst_status", 2'd3, 32'h0000_0001);
    reset = 1'b0;

    bus_write(2'd3, 32'hFFFF_FF00);
    read_check("status_ro", 2'd3, 32'h0000_0001);

    // Full-on: pattern appears one clock after the next period wrap
    led_pattern = 8'hA5;
    bus_write(2'd0, 32'd1);
    wait_pwm(8'd255);
    check("fullon_pre", {24'd0, led_out}, 32'd0);
    @(negedge clk);
    check("fullon_wrap", {24'd0, led_out}, 32'd0);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (led_out !== 8'hA5) bad++;
    end
    check("fullon_run", bad, 0);
    read_check("fullon_status", 2'd3, 32'h0000_A501);

    // PWM at DUTY=64; the same-cycle read returns the old DUTY
    led_pattern = 8'h0F;
    address     = 2'd1;
    writedata   = 32'd64;
    chipselect  = 1'b1;
    write_n     = 1'b0;
    #1;
    check("rd_during_wr", readdata, 32'h0000_00FF);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_check("duty_rd", 2'd1, 32'd64);
    wait_pwm(8'd255);
    @(negedge clk);
    check("pwm_wrap_off", {24'd0, led_out}, 32'd0);
    bad    = 0;
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_out === 8'h0F) on_cnt++;
      else if (led_out !== 8'h00) bad++;
      if (pwm_ref == 8'd64) check("pwm_last_on", {24'd0, led_out}, 32'h0F);
      if (pwm_ref == 8'd65) check("pwm_first_off", {24'd0, led_out}, 32'h00);
    end
    check("pwm_on_count", on_cnt, 64);
    check("pwm_bad_vals", bad, 0);

    // DUTY=0 is always off
    bus_write(2'd1, 32'd0);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_out !== 8'h00) bad++;
    end
    check("duty0_off", bad, 0);

    // Pattern change mid-period holds until the boundary
    bus_write(2'd1, 32'hFF);
    wait_pwm(8'd100);
    led_pattern = 8'hF0;
    bad = 0;
    n   = 0;
    while (pwm_ref !== 8'd1 && n < 300) begin
      if (led_out !== 8'h0F) bad++;
      @(negedge clk);
      n++;
    end
    check("glitch_hold", bad, 0);
    check("glitch_reach", {24'd0, pwm_ref}, 32'd1);
    check("glitch_new", {24'd0, led_out}, 32'hF0);

    // Blink: 12 clocks ON, 12 clocks OFF
    led_pattern = 8'h81;
    bus_write(2'd0, 32'd3);
    bus_write(2'd2, 32'd3);
    wait_led("blink_find_on", 8'h81, 600);
    wait_led("blink_find_off", 8'h00, 100);
    measure(8'h00, len);
    check("blink_off_len1", len, 12);
    measure(8'h81, len);
    check("blink_on_len1", len, 12);
    measure(8'h00, len);
    check("blink_off_len2", len, 12);
    measure(8'h81, len);
    check("blink_on_len2", len, 12);
    repeat (2) @(negedge clk);
    read_check("blink_status_off", 2'd3, 32'h0000_8100);
    bus_write(2'd2, 32'd3);
    check("restart_same", {24'd0, led_out}, 32'h00);
    @(negedge clk);
    check("restart_on", {24'd0, led_out}, 32'h81);
    read_check("restart_status", 2'd3, 32'h0000_8101);

    // Mid-run reset during OFF with PWM active
    bus_write(2'd1, 32'h80);
    address = 2'd3;
    #1;
    n = 0;
    while (readdata[0] !== 1'b0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_off_phase", {31'd0, readdata[0]}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_led", {24'd0, led_out}, 32'd0);
    read_check("mid_rst_ctrl", 2'd0, 32'h0000_0000);
    read_check("mid_rst_duty", 2'd1, 32'h0000_00FF);
    read_check("mid_rst_div", 2'd2, 32'h0000_0000);
    read_check("mid_rst_status", 2'd3, 32'h0000_0001);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (led_out !== 8'h00) bad++;
    end
    check("mid_rst_dark", bad, 0);
    read_check("mid_rst_latched", 2'd3, 32'h0000_8101);
    bus_write(2'd0, 32'd1);
    check("ctrl_same", {24'd0, led_out}, 32'h00);
    @(negedge clk);
    check("ctrl_on", {24'd0, led_out}, 32'h81);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
